// File: rtl/bictr_pkg.sv
// rtl/bictr_pkg.sv - shared types and defaults for the bictr sequencer
package bictr_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_PASS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bictr_seq_ctrl_pass_counter.sv
// rtl/bictr_seq_ctrl_pass_counter.sv - pass counter with captured target and last-pass compare
module bictr_pass_counter
    import bictr_pkg::*;
#(
    parameter int PASS_W = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [PASS_W-1:0] target,
    input  logic              inc,
    output logic [PASS_W-1:0] count,
    output logic              last_pass
);

    logic [PASS_W-1:0] tgt_q;
    logic [PASS_W-1:0] cnt_q;

    // A zero pass request still runs one pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            tgt_q <= (target == '0) ? PASS_W'(1) : target;
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + PASS_W'(1);
        end
    end

    assign count     = cnt_q;
    assign last_pass = ((cnt_q + PASS_W'(1)) == tgt_q);

endmodule

// File: rtl/bictr_seq_ctrl.sv
// rtl/bictr_seq_ctrl.sv - command sequencer driving one up/down counter through multiple passes
module bictr_seq_ctrl
    import bictr_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PASS_W = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [WIDTH-1:0]  cmd_count_to,
    input  logic              cmd_up_dn,
    input  logic [PASS_W-1:0] cmd_passes,
    input  logic              cmd_pingpong,
    input  logic              hold,
    input  logic              abort,
    input  logic              tercnt,
    output logic              load,
    output logic              cen,
    output logic              up_dn,
    output logic [WIDTH-1:0]  data,
    output logic [WIDTH-1:0]  count_to,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [PASS_W-1:0] pass_cnt
);

    state_t state_q;
    state_t state_d;
    logic   capture;
    logic   pass_inc;
    logic   swap;
    logic   abort_hit;
    logic   last_pass;
    logic   pingpong_q;

    bictr_pass_counter #(.PASS_W(PASS_W)) u_pass (
        .clk       (clk),
        .reset     (reset),
        .clear     (capture),
        .target    (cmd_passes),
        .inc       (pass_inc),
        .count     (pass_cnt),
        .last_pass (last_pass)
    );

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        pass_inc  = 1'b0;
        swap      = 1'b0;
        abort_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (tercnt && !hold) begin
                    pass_inc = 1'b1;
                    state_d  = last_pass ? ST_DONE : ST_LOAD;
                    swap     = pingpong_q && !last_pass;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything outside IDLE, including a pass ending this cycle.
        if (state_q != ST_IDLE && abort) begin
            state_d   = ST_IDLE;
            pass_inc  = 1'b0;
            swap      = 1'b0;
            abort_hit = 1'b1;
        end
    end

    // Stopping on tercnt keeps the counter from stepping past the target.
    assign cen = (state_q == ST_RUN) && !hold && !tercnt && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            load       <= 1'b1;
            up_dn      <= 1'b1;
            data       <= '0;
            count_to   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            pingpong_q <= 1'b0;
        end else begin
            state_q <= state_d;
            load    <= (state_d != ST_LOAD);
            busy    <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            done    <= (state_d == ST_DONE);
            aborted <= abort_hit;
            if (capture) begin
                data       <= cmd_data;
                count_to   <= cmd_count_to;
                up_dn      <= cmd_up_dn;
                pingpong_q <= cmd_pingpong;
            end else if (swap) begin
                data     <= count_to;
                count_to <= data;
                up_dn    <= !up_dn;
            end
        end
    end

endmodule
